// File: rtl/axi_rw_arb_if.sv
// Handshake bundle: write/read beat requesters into the arbiter, arbiter out to the async FIFO.
// slave = arbiter side, master = requester/FIFO side.
interface axi_rw_arb_if #(
  parameter int unsigned ID_NUM = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned PW = 1 + ID_NUM + ADDR_W + DATA_W / 8 + DATA_W;

  logic                     wr_vld_i;
  logic                     wr_rdy_o;
  logic                     wr_last_i;
  logic [PW-2:0]            wr_payload_i;
  logic                     rd_vld_i;
  logic                     rd_rdy_o;
  logic                     rd_last_i;
  logic [ID_NUM+ADDR_W-1:0] rd_payload_i;
  logic                     afifo_wvld;
  logic                     afifo_wrdy;
  logic [PW-1:0]            afifo_wpayload;

  modport slave (
    input  wr_vld_i, wr_last_i, wr_payload_i,
    input  rd_vld_i, rd_last_i, rd_payload_i,
    input  afifo_wrdy,
    output wr_rdy_o, rd_rdy_o, afifo_wvld, afifo_wpayload
  );

  modport master (
    output wr_vld_i, wr_last_i, wr_payload_i,
    output rd_vld_i, rd_last_i, rd_payload_i,
    output afifo_wrdy,
    input  wr_rdy_o, rd_rdy_o, afifo_wvld, afifo_wpayload
  );
endinterface

// File: rtl/axi_rw_arb.sv
// Burst-locked read/write arbiter feeding an async-FIFO write port through a one-entry slot.
// Tie policy: round-robin by default; write always wins ties when AXI_ARB_WR_PRIO_EN is defined.
module axi_rw_arb #(
  parameter int unsigned ID_NUM = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic        ACLK_i,
  input  logic        ARESETn_i,
  axi_rw_arb_if.slave io_bus,
  output logic [1:0]  arb_state_o,
  output logic [8:0]  arb_beat_cnt_o
);

  localparam int unsigned PW = 1 + ID_NUM + ADDR_W + DATA_W / 8 + DATA_W;
  localparam int unsigned ZW = DATA_W / 8 + DATA_W;
  localparam logic [8:0]  CntMax = 9'd256;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StWrGnt = 2'b01,
    StRdGnt = 2'b10
  } arb_state_e;

  arb_state_e    r_state;
  arb_state_e    w_state_d;
  logic          r_vld;
  logic [PW-1:0] r_payload;
  logic [8:0]    r_cnt;
  logic          w_slot_free;
  logic          w_wr_rdy;
  logic          w_rd_rdy;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_tie_wr;

  assign w_slot_free = !r_vld || io_bus.afifo_wrdy;
  assign w_wr_acc    = io_bus.wr_vld_i && w_wr_rdy;
  assign w_rd_acc    = io_bus.rd_vld_i && w_rd_rdy;

`ifdef AXI_ARB_WR_PRIO_EN
  assign w_tie_wr = 1'b1;
`else
  // Set when the most recent grant went to the write side; reset favours write first.
  logic r_last_wr;

  assign w_tie_wr = !r_last_wr;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_last_wr <= 1'b0;
    end else if (r_state == StIdle && w_state_d != StIdle) begin
      r_last_wr <= (w_state_d == StWrGnt);
    end
  end
`endif

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (io_bus.wr_vld_i && io_bus.rd_vld_i) begin
          w_state_d = w_tie_wr ? StWrGnt : StRdGnt;
        end else if (io_bus.wr_vld_i) begin
          w_state_d = StWrGnt;
        end else if (io_bus.rd_vld_i) begin
          w_state_d = StRdGnt;
        end
      end
      StWrGnt: if (w_wr_acc && io_bus.wr_last_i) w_state_d = StIdle;
      StRdGnt: if (w_rd_acc && io_bus.rd_last_i) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_wr_rdy = 1'b0;
    w_rd_rdy = 1'b0;
    case (r_state)
      StWrGnt: w_wr_rdy = w_slot_free;
      StRdGnt: w_rd_rdy = w_slot_free;
      default: ;
    endcase
  end

  // Output slot: loads on acceptance, holds while the FIFO stalls, empties when drained.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_vld     <= 1'b0;
      r_payload <= '0;
    end else if (w_wr_acc) begin
      r_vld     <= 1'b1;
      r_payload <= {1'b1, io_bus.wr_payload_i};
    end else if (w_rd_acc) begin
      r_vld     <= 1'b1;
      r_payload <= {1'b0, io_bus.rd_payload_i, {ZW{1'b0}}};
    end else if (io_bus.afifo_wrdy) begin
      r_vld     <= 1'b0;
    end
  end

  // Count survives the bubble cycle so the final burst length is visible once in IDLE.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_cnt <= '0;
    end else if (r_state == StIdle) begin
      r_cnt <= '0;
    end else if ((w_wr_acc || w_rd_acc) && r_cnt != CntMax) begin
      r_cnt <= r_cnt + 9'd1;
    end
  end

  assign io_bus.wr_rdy_o       = w_wr_rdy;
  assign io_bus.rd_rdy_o       = w_rd_rdy;
  assign io_bus.afifo_wvld     = r_vld;
  assign io_bus.afifo_wpayload = r_payload;
  assign arb_state_o           = r_state;
  assign arb_beat_cnt_o        = r_cnt;

endmodule

// File: tb/tb_axi_rw_arb.sv
// Self-checking bench for axi_rw_arb: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_axi_rw_arb;
  localparam int unsigned ID_NUM = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PW     = 1 + ID_NUM + ADDR_W + DATA_W / 8 + DATA_W;
`ifdef AXI_ARB_WR_PRIO_EN
  localparam bit WrPrio = 1'b1;
`else
  localparam bit WrPrio = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] arb_state_o;
  logic [8:0] arb_beat_cnt_o;
  int         total;
  int         bad;

  always #5 clk = ~clk;

  axi_rw_arb_if #(.ID_NUM(ID_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_rw_arb #(.ID_NUM(ID_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK_i         (clk),
    .ARESETn_i      (rst_n),
    .io_bus         (bus),
    .arb_state_o    (arb_state_o),
    .arb_beat_cnt_o (arb_beat_cnt_o)
  );

  task automatic idle_inputs();
    bus.wr_vld_i     = 1'b0;
    bus.wr_last_i    = 1'b0;
    bus.wr_payload_i = '0;
    bus.rd_vld_i     = 1'b0;
    bus.rd_last_i    = 1'b0;
    bus.rd_payload_i = '0;
    bus.afifo_wrdy   = 1'b1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_vld_i = 1'b1;
    bus.rd_vld_i = 1'b1;
    @(negedge clk);
    #1;
    total++; if (arb_state_o !== 2'b00) begin bad++; $display("FAIL reset_state got %0d want 0", arb_state_o); end
    total++; if (bus.afifo_wvld !== 1'b0) begin bad++; $display("FAIL reset_wvld got %b want 0", bus.afifo_wvld); end
    total++; if (bus.afifo_wpayload !== '0) begin bad++; $display("FAIL reset_payload got %h want 0", bus.afifo_wpayload); end
    total++; if (bus.wr_rdy_o !== 1'b0 || bus.rd_rdy_o !== 1'b0) begin
      bad++; $display("FAIL reset_rdy got wr=%b rd=%b want 0 0", bus.wr_rdy_o, bus.rd_rdy_o);
    end
    total++; if (arb_beat_cnt_o !== 9'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", arb_beat_cnt_o); end
    idle_inputs();
  endtask

  task automatic test_write_burst();
    int beat = 0, outn = 0, first_c = -1, last_c = -1;
    int unsigned maxcnt = 0;
    logic [PW-1:0] exp;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      bus.wr_vld_i     = (beat < 4);
      bus.wr_last_i    = (beat == 3);
      bus.wr_payload_i = {4'h5, 12'h100 + 12'(beat * 4), 4'hF, 32'hC0DE_0000 + 32'(beat)};
      #1;
      if (bus.afifo_wvld) begin
        exp = {1'b1, 4'h5, 12'h100 + 12'(outn * 4), 4'hF, 32'hC0DE_0000 + 32'(outn)};
        total++;
        if (bus.afifo_wpayload !== exp) begin
          bad++; $display("FAIL wr_burst_payload beat %0d got %h want %h", outn, bus.afifo_wpayload, exp);
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        outn++;
      end
      if (32'(arb_beat_cnt_o) > maxcnt) maxcnt = 32'(arb_beat_cnt_o);
      if (bus.wr_vld_i && bus.wr_rdy_o) beat++;
      @(negedge clk);
    end
    total++; if (outn != 4) begin bad++; $display("FAIL wr_burst_count got %0d want 4", outn); end
    total++; if (first_c != 2) begin bad++; $display("FAIL wr_burst_latency first valid cycle %0d want 2", first_c); end
    total++; if (last_c - first_c != 3) begin bad++; $display("FAIL wr_burst_consecutive span %0d want 3", last_c - first_c); end
    total++; if (maxcnt != 4) begin bad++; $display("FAIL wr_burst_cnt_max got %0d want 4", maxcnt); end
    total++; if (arb_beat_cnt_o !== 9'd0 || arb_state_o !== 2'b00) begin
      bad++; $display("FAIL wr_burst_end got cnt=%0d state=%0d want 0 0", arb_beat_cnt_o, arb_state_o);
    end
  endtask

  task automatic test_stall();
    int beat = 0, got = 0;
    logic [31:0] d [4];
    logic [PW-1:0] prev_p, exp;
    bit prev_hold = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = $urandom();
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      bus.afifo_wrdy   = !(c >= 3 && c < 8);
      bus.wr_vld_i     = (beat < 4);
      bus.wr_last_i    = (beat == 3);
      bus.wr_payload_i = {4'h9, 12'h200 + 12'(beat * 4), 4'h3, d[beat % 4]};
      #1;
      if (prev_hold) begin
        total++;
        if (bus.afifo_wvld !== 1'b1 || bus.afifo_wpayload !== prev_p) begin
          bad++; $display("FAIL stall_hold got vld=%b %h want 1 %h", bus.afifo_wvld, bus.afifo_wpayload, prev_p);
        end
      end
      if (bus.afifo_wvld && !bus.afifo_wrdy) begin
        total++; if (bus.wr_rdy_o !== 1'b0) begin bad++; $display("FAIL stall_rdy got %b want 0", bus.wr_rdy_o); end
      end
      if (bus.afifo_wvld && bus.afifo_wrdy) begin
        total++;
        if (got >= 4) begin
          bad++; $display("FAIL stall_extra_beat got %h want none", bus.afifo_wpayload);
        end else begin
          exp = {1'b1, 4'h9, 12'h200 + 12'(got * 4), 4'h3, d[got]};
          if (bus.afifo_wpayload !== exp) begin
            bad++; $display("FAIL stall_payload beat %0d got %h want %h", got, bus.afifo_wpayload, exp);
          end
        end
        got++;
      end
      if (bus.wr_vld_i && bus.wr_rdy_o) beat++;
      prev_hold = bus.afifo_wvld && !bus.afifo_wrdy;
      prev_p    = bus.afifo_wpayload;
      @(negedge clk);
    end
    total++; if (got != 4) begin bad++; $display("FAIL stall_count got %0d want 4", got); end
  endtask

  task automatic test_read_payload();
    int nacc = 0, nout = 0;
    bit acc;
    logic [PW-1:0] exp;
    exp = {1'b0, 4'h3, 12'h0F0, 4'h0, 32'h0};
    apply_reset();
    bus.rd_vld_i     = 1'b1;
    bus.rd_last_i    = 1'b1;
    bus.rd_payload_i = {4'h3, 12'h0F0};
    for (int c = 0; c < 8; c++) begin
      #1;
      acc = bus.rd_vld_i && bus.rd_rdy_o;
      if (acc) nacc++;
      if (bus.afifo_wvld) begin
        nout++;
        total++; if (bus.afifo_wpayload !== exp) begin
          bad++; $display("FAIL rd_payload got %h want %h", bus.afifo_wpayload, exp);
        end
        total++; if (arb_state_o !== 2'b00) begin
          bad++; $display("FAIL rd_single_idle got state %0d want 0", arb_state_o);
        end
      end
      @(negedge clk);
      if (acc) bus.rd_vld_i = 1'b0;
    end
    total++; if (nacc != 1 || nout != 1) begin
      bad++; $display("FAIL rd_single_count got acc=%0d out=%0d want 1 1", nacc, nout);
    end
  endtask

  // Both sides keep requesting; expected burst order comes from the tie rule alone.
  task automatic test_arbitration(input int nb, input int bl);
    bit exp_side[$];
    int wleft = nb, rleft = nb, wi = 0, ri = 0, ow = 0, orr = 0, n = 0, nexp;
    bit last_wr = 1'b0, pick_w, acc_w, acc_r;
    logic [PW-1:0] exp;
    while (wleft > 0 || rleft > 0) begin
      if (wleft > 0 && rleft > 0) pick_w = WrPrio ? 1'b1 : !last_wr;
      else pick_w = (wleft > 0);
      for (int k = 0; k < bl; k++) exp_side.push_back(pick_w);
      last_wr = pick_w;
      if (pick_w) wleft--; else rleft--;
    end
    nexp = exp_side.size();
    apply_reset();
    for (int c = 0; c < 400 && n < nexp; c++) begin
      bus.wr_vld_i     = (wi < nb * bl);
      bus.wr_last_i    = ((wi % bl) == bl - 1);
      bus.wr_payload_i = {4'(wi), 12'(wi * 4), 4'hF, 32'(wi)};
      bus.rd_vld_i     = (ri < nb * bl);
      bus.rd_last_i    = ((ri % bl) == bl - 1);
      bus.rd_payload_i = {4'(ri), 12'h800 + 12'(ri)};
      #1;
      if (bus.afifo_wvld && bus.afifo_wrdy) begin
        total++;
        if (bus.afifo_wpayload[PW-1] !== exp_side[n]) begin
          bad++; $display("FAIL arb_order beat %0d got is_write=%b want %b", n, bus.afifo_wpayload[PW-1], exp_side[n]);
        end
        if (exp_side[n]) begin
          exp = {1'b1, 4'(ow), 12'(ow * 4), 4'hF, 32'(ow)};
          ow++;
        end else begin
          exp = {1'b0, 4'(orr), 12'h800 + 12'(orr), 36'h0};
          orr++;
        end
        total++;
        if (bus.afifo_wpayload !== exp) begin
          bad++; $display("FAIL arb_payload beat %0d got %h want %h", n, bus.afifo_wpayload, exp);
        end
        n++;
      end
      acc_w = bus.wr_vld_i && bus.wr_rdy_o;
      acc_r = bus.rd_vld_i && bus.rd_rdy_o;
      @(negedge clk);
      if (acc_w) wi++;
      if (acc_r) ri++;
    end
    total++; if (n != nexp) begin bad++; $display("FAIL arb_timeout got %0d beats want %0d", n, nexp); end
  endtask

  task automatic test_reset_mid();
    int beat = 0, got = 0;
    bit hit = 1'b0;
    logic [PW-1:0] exp;
    apply_reset();
    for (int c = 0; c < 10 && !hit; c++) begin
      bus.wr_vld_i     = 1'b1;
      bus.wr_last_i    = (beat == 3);
      bus.wr_payload_i = {4'hA, 12'h300 + 12'(beat * 4), 4'hF, 32'hDEAD_0000 + 32'(beat)};
      #1;
      if (beat == 1 && bus.wr_rdy_o) begin
        hit = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if (arb_state_o !== 2'b00) begin bad++; $display("FAIL rst_mid_state got %0d want 0", arb_state_o); end
        total++; if (bus.afifo_wvld !== 1'b0) begin bad++; $display("FAIL rst_mid_wvld got %b want 0", bus.afifo_wvld); end
        total++; if (bus.afifo_wpayload !== '0) begin bad++; $display("FAIL rst_mid_payload got %h want 0", bus.afifo_wpayload); end
        total++; if (bus.wr_rdy_o !== 1'b0 || bus.rd_rdy_o !== 1'b0) begin
          bad++; $display("FAIL rst_mid_rdy got wr=%b rd=%b want 0 0", bus.wr_rdy_o, bus.rd_rdy_o);
        end
        total++; if (arb_beat_cnt_o !== 9'd0) begin bad++; $display("FAIL rst_mid_cnt got %0d want 0", arb_beat_cnt_o); end
      end else begin
        if (bus.wr_rdy_o) beat++;
        @(negedge clk);
      end
    end
    total++; if (!hit) begin bad++; $display("FAIL rst_mid_not_reached got beat %0d want 1", beat); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat = 0;
    for (int c = 0; c < 10; c++) begin
      bus.wr_vld_i     = (beat < 2);
      bus.wr_last_i    = (beat == 1);
      bus.wr_payload_i = {4'hB, 12'h400 + 12'(beat * 4), 4'h1, 32'h1234_0000 + 32'(beat)};
      #1;
      if (beat == 0 && bus.wr_vld_i && bus.wr_rdy_o) begin
        total++; if (arb_beat_cnt_o !== 9'd0) begin bad++; $display("FAIL rst_new_cnt got %0d want 0", arb_beat_cnt_o); end
      end
      if (bus.afifo_wvld && bus.afifo_wrdy) begin
        exp = {1'b1, 4'hB, 12'h400 + 12'(got * 4), 4'h1, 32'h1234_0000 + 32'(got)};
        total++; if (bus.afifo_wpayload !== exp) begin
          bad++; $display("FAIL rst_new_payload beat %0d got %h want %h", got, bus.afifo_wpayload, exp);
        end
        got++;
      end
      if (bus.wr_vld_i && bus.wr_rdy_o) beat++;
      @(negedge clk);
    end
    total++; if (got != 2) begin bad++; $display("FAIL rst_new_count got %0d want 2", got); end
  endtask

  task automatic test_random();
    logic [PW-2:0]            wq[$];
    bit                       wl[$];
    logic [ID_NUM+ADDR_W-1:0] rq[$];
    bit                       rl[$];
    logic [PW-1:0]            expq[$];
    logic [PW-1:0]            prev_p, prev_acc_p, exp;
    logic [63:0]              r64;
    int  len, wi = 0, ri = 0, lock = 0, c = 0;
    bit  prev_hold = 1'b0, prev_acc = 1'b0, prev_last = 1'b0, acc_w, acc_r;
    for (int b = 0; b < 10; b++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        r64 = {$urandom(), $urandom()};
        wq.push_back(r64[PW-2:0]);
        wl.push_back(k == len - 1);
      end
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        r64 = {$urandom(), $urandom()};
        rq.push_back(r64[ID_NUM+ADDR_W-1:0]);
        rl.push_back(k == len - 1);
      end
    end
    apply_reset();
    while ((wi < wq.size() || ri < rq.size() || expq.size() != 0) && c < 3000) begin
      bus.wr_vld_i     = (wi < wq.size()) && ($urandom_range(0, 3) != 0);
      bus.wr_payload_i = (wi < wq.size()) ? wq[wi] : '0;
      bus.wr_last_i    = (wi < wq.size()) ? wl[wi] : 1'b0;
      bus.rd_vld_i     = (ri < rq.size()) && ($urandom_range(0, 3) != 0);
      bus.rd_payload_i = (ri < rq.size()) ? rq[ri] : '0;
      bus.rd_last_i    = (ri < rq.size()) ? rl[ri] : 1'b0;
      bus.afifo_wrdy   = ($urandom_range(0, 3) != 0);
      #1;
      total++; if (bus.wr_rdy_o && bus.rd_rdy_o) begin bad++; $display("FAIL rnd_both_rdy got 1 1 want not both"); end
      if (bus.afifo_wvld && !bus.afifo_wrdy) begin
        total++; if (bus.wr_rdy_o || bus.rd_rdy_o) begin
          bad++; $display("FAIL rnd_full_rdy got wr=%b rd=%b want 0 0", bus.wr_rdy_o, bus.rd_rdy_o);
        end
      end
      if (prev_hold) begin
        total++; if (!bus.afifo_wvld || bus.afifo_wpayload !== prev_p) begin
          bad++; $display("FAIL rnd_hold got vld=%b %h want 1 %h", bus.afifo_wvld, bus.afifo_wpayload, prev_p);
        end
      end
      if (prev_acc) begin
        total++; if (!bus.afifo_wvld || bus.afifo_wpayload !== prev_acc_p) begin
          bad++; $display("FAIL rnd_latency got vld=%b %h want 1 %h", bus.afifo_wvld, bus.afifo_wpayload, prev_acc_p);
        end
      end
      if (prev_last) begin
        total++; if (arb_state_o !== 2'b00 || bus.wr_rdy_o || bus.rd_rdy_o) begin
          bad++; $display("FAIL rnd_bubble got state=%0d wr=%b rd=%b want 0 0 0", arb_state_o, bus.wr_rdy_o, bus.rd_rdy_o);
        end
      end
      if (lock != 0) begin
        total++; if (arb_state_o !== 2'(lock) || (lock == 1 && bus.rd_rdy_o) || (lock == 2 && bus.wr_rdy_o)) begin
          bad++; $display("FAIL rnd_lock got state=%0d wr=%b rd=%b want state %0d", arb_state_o, bus.wr_rdy_o, bus.rd_rdy_o, lock);
        end
      end
      if (bus.afifo_wvld && bus.afifo_wrdy) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected got %h want none", bus.afifo_wpayload);
        end else begin
          exp = expq.pop_front();
          if (bus.afifo_wpayload !== exp) begin
            bad++; $display("FAIL rnd_payload got %h want %h", bus.afifo_wpayload, exp);
          end
        end
      end
      acc_w     = bus.wr_vld_i && bus.wr_rdy_o;
      acc_r     = bus.rd_vld_i && bus.rd_rdy_o;
      prev_acc  = acc_w || acc_r;
      prev_last = 1'b0;
      if (acc_w) begin
        prev_acc_p = {1'b1, wq[wi]};
        expq.push_back(prev_acc_p);
        prev_last = wl[wi];
        lock = wl[wi] ? 0 : 1;
        wi++;
      end else if (acc_r) begin
        prev_acc_p = {1'b0, rq[ri], 36'h0};
        expq.push_back(prev_acc_p);
        prev_last = rl[ri];
        lock = rl[ri] ? 0 : 2;
        ri++;
      end
      prev_hold = bus.afifo_wvld && !bus.afifo_wrdy;
      prev_p    = bus.afifo_wpayload;
      @(negedge clk);
      c++;
    end
    total++; if (wi != wq.size() || ri != rq.size() || expq.size() != 0) begin
      bad++; $display("FAIL rnd_drain got wr=%0d rd=%0d pending=%0d want %0d %0d 0", wi, ri, expq.size(), wq.size(), rq.size());
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_write_burst();
    test_stall();
    test_read_payload();
    test_arbitration(2, 2);
    test_arbitration(6, 1);
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
